sdram_burst_reader: RTL and testbench

- Upstream/downstream companion to the EasySDRAM controller. Takes a single "read N words from address A" request and turns it into N read commands on the controller's command-FIFO write port.
- Collects the returned readValid/raddr/rdata stream into a local buffer and presents it as a valid/ready stream, e.g. to a video or DMA consumer.
- The controller's read port has no backpressure, so the block uses credit accounting to guarantee that returned data never overflows the local buffer.

---
 rtl/sdram_burst_reader.sv | 167 ++++++++++++++++
 tb/tb_sdram_burst_reader.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_reader.sv
// sdram_burst_reader
//   Turns one "read <length> words starting at <startAddr>" request into a
//   sequence of read commands on the SDRAM controller's command FIFO, collects
//   the returned readout stream into a local buffer and presents it as a
//   valid/ready stream. The controller readout has no backpressure, so a
//   command is only issued while (commands in flight + words buffered) is
//   below BUF_DEPTH; returned data therefore always has a free buffer slot.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   start/startAddr/length   request (accepted only while busy=0)
//   busy, done, err     status (done is a 1-cycle pulse, err is sticky)
//   cmd*                controller command-FIFO write port (read commands only)
//   readValid/raddr/rdata    controller readout stream
//   outValid/outReady/outData/outLast   buffered output stream
module sdram_burst_reader #(
  parameter int BUF_DEPTH = 16,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [24:0]      startAddr,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             cmdWrite,
  input  logic             cmdFull,
  output logic             cmdIsWrite,
  output logic [24:0]      cmdAddress,
  output logic [1:0]       cmdWriteMask,
  output logic [15:0]      cmdWriteData,
  input  logic             readValid,
  input  logic [24:0]      raddr,
  input  logic [15:0]      rdata,
  output logic             outValid,
  input  logic             outReady,
  output logic [15:0]      outData,
  output logic             outLast
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_LIM = (CW+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [24:0]      issue_addr_reg;
  logic [24:0]      exp_addr_reg;
  logic [LEN_W-1:0] issue_left_reg;
  logic [LEN_W-1:0] ret_left_reg;
  logic [LEN_W-1:0] out_left_reg;
  logic [CW-1:0]    inflight_reg;
  logic [CW-1:0]    buf_count_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic             err_reg;
  logic             done_reg;

  logic [15:0] mem [BUF_DEPTH];

  logic          start_ok;
  logic          start_burst;
  logic          issue;
  logic          push;
  logic          stray;
  logic          pop;
  logic          drain_done;
  logic [CW:0]   credit_sum;

  assign start_ok    = start & (state_reg == IDLE);
  assign start_burst = start_ok & (length != '0);
  // Every issued command reserves a buffer slot until its word is popped.
  assign credit_sum  = {1'b0, inflight_reg} + {1'b0, buf_count_reg};
  assign issue       = (state_reg == ISSUE) & (issue_left_reg != '0) & ~cmdFull
                       & (credit_sum < DEPTH_LIM);
  assign push        = readValid & (ret_left_reg != '0);
  assign stray       = readValid & (ret_left_reg == '0);
  assign pop         = (buf_count_reg != '0) & outReady;
  assign drain_done  = (state_reg == DRAIN) & (issue_left_reg == '0) &
                       (inflight_reg == '0) & (buf_count_reg == '0) &
                       (out_left_reg == '0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_burst) state_next = ISSUE;
      ISSUE:   if ((issue_left_reg == '0) ||
                   (issue && (issue_left_reg == LEN_W'(1)))) state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      issue_addr_reg <= '0;
      exp_addr_reg   <= '0;
      issue_left_reg <= '0;
      ret_left_reg   <= '0;
      out_left_reg   <= '0;
      inflight_reg   <= '0;
      buf_count_reg  <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      err_reg        <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      // A zero-length request completes immediately without issuing anything.
      done_reg  <= drain_done | (start_ok & (length == '0));

      if (start_burst) begin
        issue_addr_reg <= startAddr;
        exp_addr_reg   <= startAddr;
        issue_left_reg <= length;
        ret_left_reg   <= length;
        out_left_reg   <= length;
      end else begin
        if (issue) begin
          issue_addr_reg <= issue_addr_reg + 25'd1;
          issue_left_reg <= issue_left_reg - LEN_W'(1);
        end
        if (push) begin
          exp_addr_reg <= exp_addr_reg + 25'd1;
          ret_left_reg <= ret_left_reg - LEN_W'(1);
        end
        if (pop) out_left_reg <= out_left_reg - LEN_W'(1);
      end

      inflight_reg  <= inflight_reg + CW'(issue) - CW'(push);
      buf_count_reg <= buf_count_reg + CW'(push) - CW'(pop);
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);

      // A new request clears the flag, but an error seen in the same cycle wins.
      if (start_ok) err_reg <= 1'b0;
      if (stray || (push && (raddr != exp_addr_reg))) err_reg <= 1'b1;
    end
  end

  // Buffer storage: mismatched-address data is still stored, stray data is not.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= rdata;
  end

  assign busy         = (state_reg != IDLE);
  assign done         = done_reg;
  assign err          = err_reg;
  assign cmdWrite     = issue;
  assign cmdIsWrite   = 1'b0;
  assign cmdAddress   = issue_addr_reg;
  assign cmdWriteMask = 2'b11;
  assign cmdWriteData = 16'h0000;
  assign outValid     = (buf_count_reg != '0);
  assign outData      = mem[rd_ptr_reg];
  assign outLast      = outValid & (out_left_reg == LEN_W'(1));

endmodule

// File: tb/tb_sdram_burst_reader.sv
module tb_sdram_burst_reader;

  localparam int BUF_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [24:0] startAddr = '0;
  logic [15:0] length = '0;
  logic        busy, done, err;
  logic        cmdWrite;
  logic        cmdFull = 1'b0;
  logic        cmdIsWrite;
  logic [24:0] cmdAddress;
  logic [1:0]  cmdWriteMask;
  logic [15:0] cmdWriteData;
  logic        readValid = 1'b0;
  logic [24:0] raddr = '0;
  logic [15:0] rdata = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [15:0] outData;
  logic        outLast;

  sdram_burst_reader #(.BUF_DEPTH(BUF_DEPTH), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .startAddr(startAddr), .length(length),
    .busy(busy), .done(done), .err(err),
    .cmdWrite(cmdWrite), .cmdFull(cmdFull), .cmdIsWrite(cmdIsWrite),
    .cmdAddress(cmdAddress), .cmdWriteMask(cmdWriteMask), .cmdWriteData(cmdWriteData),
    .readValid(readValid), .raddr(raddr), .rdata(rdata),
    .outValid(outValid), .outReady(outReady), .outData(outData), .outLast(outLast)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  // Memory contents seen by the controller model: word at address a.
  function automatic logic [15:0] dv(input logic [24:0] a);
    return a[15:0] ^ 16'hA400;
  endfunction

  // ---------------- controller model ----------------
  typedef struct {
    logic [24:0] a;
    int          due;
  } cmd_t;
  cmd_t cq[$];
  int cyc = 0;
  bit hold_ret = 0;
  bit corrupt_next = 0;
  bit stray_req = 0;
  int lat_rand = 0;
  bit rand_ready = 0;
  bit rand_full = 0;

  always @(posedge clk) begin
    cmd_t c;
    cyc++;
    #1;
    readValid = 1'b0;
    if (rst && !hold_ret && cq.size() > 0 && cq[0].due <= cyc) begin
      c = cq.pop_front();
      readValid = 1'b1;
      raddr = corrupt_next ? (c.a ^ 25'h10) : c.a;
      corrupt_next = 0;
      rdata = dv(c.a);
    end else if (rst && stray_req && cq.size() == 0) begin
      readValid = 1'b1;
      raddr = 25'($urandom);
      rdata = 16'($urandom);
      stray_req = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) outReady = 1'($urandom_range(0, 1));
    if (rand_full)  cmdFull  = ($urandom_range(0, 3) == 0);
  end

  // ---------------- behavioural model + compare ----------------
  logic [24:0] mbase = '0;
  int  mlen = 0, issued = 0, returned = 0, popped = 0;
  bit  busy_m = 0, err_m = 0;
  int  done_cyc = -1;
  int  done_count = 0;
  logic [24:0] cmd_log[$];
  int          cmd_cyc[$];
  logic [15:0] out_log[$];

  function automatic logic [24:0] addr_at(input int k);
    return mbase + 25'(k);
  endfunction

  always @(negedge clk) begin
    bit exp_cw, err_ev;
    cmd_t c;
    int buffered;
    if (!rst) begin
      busy_m = 0; err_m = 0; done_cyc = -1;
      mlen = 0; issued = 0; returned = 0; popped = 0;
      cq.delete();
    end else begin
      err_ev = 0;
      if (cyc == done_cyc) busy_m = 0;
      chk("busy", 32'(busy), 32'(busy_m));
      chk("done", 32'(done), 32'(cyc == done_cyc));
      if (done) done_count++;
      chk("err", 32'(err), 32'(err_m));
      chk("cmd_consts", {13'd0, cmdIsWrite, cmdWriteMask, cmdWriteData}, {13'd0, 1'b0, 2'b11, 16'h0});
      exp_cw = busy_m && (issued < mlen) && !cmdFull && ((issued - popped) < BUF_DEPTH);
      chk("cmdWrite", 32'(cmdWrite), 32'(exp_cw));
      if (cmdWrite) begin
        chk("cmdAddress", 32'(cmdAddress), 32'(addr_at(issued)));
        c.a = cmdAddress;
        c.due = cyc + 3 + int'($urandom_range(0, lat_rand));
        cq.push_back(c);
        cmd_log.push_back(cmdAddress);
        cmd_cyc.push_back(cyc);
        issued++;
      end
      buffered = returned - popped;
      chk("outValid", 32'(outValid), 32'(buffered > 0));
      chk("outLast", 32'(outLast), 32'((buffered > 0) && (popped == mlen - 1)));
      if (outValid && outReady) begin
        chk("outData", 32'(outData), 32'(dv(addr_at(popped))));
        out_log.push_back(outData);
        popped++;
        if (popped == mlen) done_cyc = cyc + 2;
      end
      if (readValid) begin
        if (returned < mlen) begin
          if (raddr != addr_at(returned)) err_ev = 1;
          returned++;
        end else begin
          err_ev = 1;
        end
      end
      if (start && !busy_m) begin
        err_m = 0;
        if (length == 16'd0) begin
          done_cyc = cyc + 1;
        end else begin
          busy_m = 1; done_cyc = -1;
          mbase = startAddr; mlen = int'(length);
          issued = 0; returned = 0; popped = 0;
        end
      end
      if (err_ev) err_m = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_start(input logic [24:0] a, input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; startAddr = a; length = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_count;
    int n = 0;
    while (done_count == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_count == d0) begin
      failures++;
      $display("FAIL done_timeout actual=none required=done_within_%0d", budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_logs();
    cmd_log.delete(); cmd_cyc.delete(); out_log.delete();
  endtask

  initial begin
    int d0, n;
    logic [24:0] a;
    logic [15:0] l;

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cmdWrite", 32'(cmdWrite), 0);
    chk("rst_outValid", 32'(outValid), 0);
    chk("rst_outLast", 32'(outLast), 0);
    chk("rst_cmdAddress", 32'(cmdAddress), 0);
    chk("rst_err", 32'(err), 0);
    @(posedge clk); #2; rst = 1'b1;
    repeat (2) @(posedge clk);

    // Basic burst
    outReady = 1'b1; cmdFull = 1'b0; lat_rand = 0; clear_logs();
    do_start(25'h00400, 16'd4);
    wait_done(100);
    $display("basic: cmds=%0d words=%0d", cmd_log.size(), out_log.size());
    chk("basic_ncmd", 32'(cmd_log.size()), 4);
    if (cmd_log.size() == 4) begin
      chk("basic_cmd0", 32'(cmd_log[0]), 32'h400);
      chk("basic_cmd3", 32'(cmd_log[3]), 32'h403);
      chk("basic_consecutive", 32'(cmd_cyc[3] - cmd_cyc[0]), 3);
    end
    chk("basic_nout", 32'(out_log.size()), 4);
    if (out_log.size() == 4) begin
      chk("basic_out0", 32'(out_log[0]), 32'hA000);
      chk("basic_out3", 32'(out_log[3]), 32'hA003);
    end
    chk("basic_err", 32'(err), 0);

    // Credit stall
    outReady = 1'b0; clear_logs();
    do_start(25'h0123450, 16'd40);
    repeat (60) @(negedge clk);
    $display("credit stall: cmds=%0d", cmd_log.size());
    chk("stall_ncmd", 32'(cmd_log.size()), 16);
    @(posedge clk); #1; outReady = 1'b1;
    wait_done(500);
    $display("credit resume: cmds=%0d words=%0d", cmd_log.size(), out_log.size());
    chk("stall_total_cmd", 32'(cmd_log.size()), 40);
    chk("stall_total_out", 32'(out_log.size()), 40);

    // FIFO backpressure mid-burst
    clear_logs();
    do_start(25'h0ABCDE0, 16'd30);
    repeat (4) @(posedge clk);
    #1; cmdFull = 1'b1;
    repeat (10) @(posedge clk);
    #1; cmdFull = 1'b0;
    wait_done(500);
    $display("backpressure: cmds=%0d words=%0d", cmd_log.size(), out_log.size());
    chk("bp_ncmd", 32'(cmd_log.size()), 30);

    // Address wrap with a corrupted readout address
    clear_logs(); corrupt_next = 1;
    do_start(25'h1FFFFFE, 16'd3);
    wait_done(100);
    $display("wrap: cmds=%0d err=%0d", cmd_log.size(), err);
    chk("wrap_ncmd", 32'(cmd_log.size()), 3);
    if (cmd_log.size() == 3) begin
      chk("wrap_cmd0", 32'(cmd_log[0]), 32'h1FFFFFE);
      chk("wrap_cmd1", 32'(cmd_log[1]), 32'h1FFFFFF);
      chk("wrap_cmd2", 32'(cmd_log[2]), 32'h0);
    end
    chk("wrap_err_set", 32'(err), 1);
    do_start(25'h0000100, 16'd5);
    chk("err_cleared", 32'(err), 0);
    wait_done(100);

    // Zero length
    clear_logs(); d0 = done_count;
    do_start(25'h0000777, 16'd0);
    repeat (3) @(negedge clk);
    $display("zero length: cmds=%0d dones=%0d", cmd_log.size(), done_count - d0);
    chk("zero_ncmd", 32'(cmd_log.size()), 0);
    chk("zero_ndone", 32'(done_count - d0), 1);

    // Start while busy is ignored
    clear_logs();
    do_start(25'h0002000, 16'd8);
    do_start(25'h0005000, 16'd3);
    wait_done(200);
    $display("start while busy: cmds=%0d", cmd_log.size());
    chk("busy_start_ncmd", 32'(cmd_log.size()), 8);

    // Stray readout while idle
    @(posedge clk); #1; stray_req = 1;
    repeat (4) @(negedge clk);
    $display("stray: err=%0d", err);
    chk("stray_err", 32'(err), 1);

    // Randomised bursts
    rand_ready = 1; rand_full = 1;
    for (int i = 0; i < 8; i++) begin
      a = 25'($urandom);
      l = 16'($urandom_range(1, 50));
      lat_rand = int'($urandom_range(0, 4));
      clear_logs();
      do_start(a, l);
      wait_done(3000);
      $display("random burst %0d: addr=%h len=%0d cmds=%0d words=%0d", i, a, l, cmd_log.size(), out_log.size());
      chk("rand_nout", 32'(out_log.size()), 32'(l));
    end
    rand_ready = 0; rand_full = 0;
    @(posedge clk); #1; outReady = 1'b0; cmdFull = 1'b0; lat_rand = 0;

    // Asynchronous reset with five reads in flight
    clear_logs(); hold_ret = 1;
    do_start(25'h0040000, 16'd20);
    n = 0;
    while (cmd_log.size() < 5 && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    #1; rst = 1'b0;
    #1;
    $display("async reset: inflight=%0d busy=%0d outValid=%0d", cmd_log.size(), busy, outValid);
    chk("arst_inflight", 32'(cmd_log.size()), 5);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_cmdWrite", 32'(cmdWrite), 0);
    chk("arst_cmdAddress", 32'(cmdAddress), 0);
    chk("arst_outLast", 32'(outLast), 0);
    hold_ret = 0;
    repeat (2) @(posedge clk);
    #2; rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_outValid", 32'(outValid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
